// File: rtl/scalar_mult_ctrl.sv
// Double-and-add sequencer for twisted-Edwards scalar multiplication.
// Every group operation is delegated to one external point_add unit over start/done.
module scalar_mult_ctrl #(
    parameter int NBITS = 256,
    parameter int W     = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NBITS-1:0] scalar,
    input  logic [W-1:0]     px,
    input  logic [W-1:0]     py,
    input  logic [W-1:0]     pz,
    input  logic [W-1:0]     pt,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     qx,
    output logic [W-1:0]     qy,
    output logic [W-1:0]     qz,
    output logic [W-1:0]     qt,
    output logic             pa_start,
    output logic [W-1:0]     pa_x1,
    output logic [W-1:0]     pa_y1,
    output logic [W-1:0]     pa_z1,
    output logic [W-1:0]     pa_t1,
    output logic [W-1:0]     pa_x2,
    output logic [W-1:0]     pa_y2,
    output logic [W-1:0]     pa_z2,
    output logic [W-1:0]     pa_t2,
    input  logic             pa_done,
    input  logic [W-1:0]     pa_x3,
    input  logic [W-1:0]     pa_y3,
    input  logic [W-1:0]     pa_z3,
    input  logic [W-1:0]     pa_t3
);

    localparam int              CW      = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0]   CNT_TOP = CW'(NBITS - 1);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [W-1:0]    ZERO_W  = {W{1'b0}};
    localparam logic [W-1:0]    ONE_W   = W'(1);
    localparam logic [1:0]      WAIT_ARMED = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DBL_ISSUE = 3'd1,
        ST_ADD_ISSUE = 3'd2,
        ST_WAIT      = 3'd3,
        ST_NEXT      = 3'd4,
        ST_FIN       = 3'd5
    } state_t;

    typedef enum logic {
        OP_DBL = 1'b0,
        OP_ADD = 1'b1
    } op_t;

    state_t           state_r;
    state_t           state_nxt_s;
    op_t              op_r;
    logic [CW-1:0]    cnt_r;
    logic [1:0]       wait_cnt_r;
    logic             pa_done_r;
    logic             busy_r;
    logic             done_r;
    logic             pa_start_r;
    logic [NBITS-1:0] scalar_r;
    logic [W-1:0]     px_r;
    logic [W-1:0]     py_r;
    logic [W-1:0]     pz_r;
    logic [W-1:0]     pt_r;
    logic [W-1:0]     qx_r;
    logic [W-1:0]     qy_r;
    logic [W-1:0]     qz_r;
    logic [W-1:0]     qt_r;
    logic [W-1:0]     x1_r;
    logic [W-1:0]     y1_r;
    logic [W-1:0]     z1_r;
    logic [W-1:0]     t1_r;
    logic [W-1:0]     x2_r;
    logic [W-1:0]     y2_r;
    logic [W-1:0]     z2_r;
    logic [W-1:0]     t2_r;
    logic             accept_s;
    logic             issue_s;
    logic             complete_s;

    function automatic logic scalar_bit(input logic [NBITS-1:0] k, input logic [CW-1:0] idx);
        return k[idx];
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; completion needs a fresh rising edge of pa_done once armed
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        issue_s     = 1'b0;
        complete_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_DBL_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DBL_ISSUE, ST_ADD_ISSUE: begin
                issue_s     = 1'b1;
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if ((wait_cnt_r == WAIT_ARMED) && pa_done && !pa_done_r) begin
                    complete_s = 1'b1;
                    if ((op_r == OP_DBL) && scalar_bit(scalar_r, cnt_r)) begin
                        state_nxt_s = ST_ADD_ISSUE;
                    end else begin
                        state_nxt_s = ST_NEXT;
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_NEXT: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_DBL_ISSUE;
                end
            end
            ST_FIN: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Control registers: handshake outputs, operation kind, bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pa_start_r <= 1'b0;
            pa_done_r  <= 1'b0;
            wait_cnt_r <= 2'd0;
            op_r       <= OP_DBL;
            cnt_r      <= CNT_TOP;
        end else begin
            pa_done_r  <= pa_done;
            pa_start_r <= issue_s;
            done_r     <= (state_nxt_s == ST_FIN);
            busy_r     <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_FIN);
            if (issue_s) begin
                wait_cnt_r <= 2'd0;
            end else if ((state_r == ST_WAIT) && (wait_cnt_r != WAIT_ARMED)) begin
                wait_cnt_r <= wait_cnt_r + 2'd1;
            end
            if (state_r == ST_DBL_ISSUE) begin
                op_r <= OP_DBL;
            end else if (state_r == ST_ADD_ISSUE) begin
                op_r <= OP_ADD;
            end
            if (accept_s) begin
                cnt_r <= CNT_TOP;
            end else if ((state_r == ST_NEXT) && (cnt_r != CNT_ZERO)) begin
                cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Coordinate registers: latched inputs, accumulator Q and point_add operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scalar_r <= {NBITS{1'b0}};
            px_r     <= ZERO_W;
            py_r     <= ZERO_W;
            pz_r     <= ZERO_W;
            pt_r     <= ZERO_W;
            qx_r     <= ZERO_W;
            qy_r     <= ONE_W;
            qz_r     <= ONE_W;
            qt_r     <= ZERO_W;
            x1_r     <= ZERO_W;
            y1_r     <= ZERO_W;
            z1_r     <= ZERO_W;
            t1_r     <= ZERO_W;
            x2_r     <= ZERO_W;
            y2_r     <= ZERO_W;
            z2_r     <= ZERO_W;
            t2_r     <= ZERO_W;
        end else begin
            if (accept_s) begin
                scalar_r <= scalar;
                px_r     <= px;
                py_r     <= py;
                pz_r     <= pz;
                pt_r     <= pt;
                qx_r     <= ZERO_W;
                qy_r     <= ONE_W;
                qz_r     <= ONE_W;
                qt_r     <= ZERO_W;
            end else if (complete_s) begin
                qx_r <= pa_x3;
                qy_r <= pa_y3;
                qz_r <= pa_z3;
                qt_r <= pa_t3;
            end
            if (issue_s) begin
                x1_r <= qx_r;
                y1_r <= qy_r;
                z1_r <= qz_r;
                t1_r <= qt_r;
                if (state_r == ST_ADD_ISSUE) begin
                    x2_r <= px_r;
                    y2_r <= py_r;
                    z2_r <= pz_r;
                    t2_r <= pt_r;
                end else begin
                    x2_r <= qx_r;
                    y2_r <= qy_r;
                    z2_r <= qz_r;
                    t2_r <= qt_r;
                end
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign pa_start = pa_start_r;
    assign qx       = qx_r;
    assign qy       = qy_r;
    assign qz       = qz_r;
    assign qt       = qt_r;
    assign pa_x1    = x1_r;
    assign pa_y1    = y1_r;
    assign pa_z1    = z1_r;
    assign pa_t1    = t1_r;
    assign pa_x2    = x2_r;
    assign pa_y2    = y2_r;
    assign pa_z2    = z2_r;
    assign pa_t2    = t2_r;

endmodule
